// File: rtl/instruction_decode.sv
// Purpose: pipeline decode stage; splits the instruction, reads Rs/Rd from an 8x16 register file, decodes the control word.
// Latency: one cycle from instruction to Rs_data/Rd_data/control_signals (this block holds the ID/EX register).
// Backpressure: none; one instruction is accepted every cycle, and rst turns the next output into a bubble.
//
// Ports:
//   clk                                  rising-edge clock
//   rst                                  synchronous flush; clears the outputs only
//   rstAll                               synchronous full reset; clears the outputs and R0..R7
//   instruction                          [15:11] opcode, [10:8] Rs, [7:5] Rd, [4:0] shamt/imm (not used here)
//   WB_data, WB_address, write_enable    write-back port from the WB stage
//   Rs_data, Rd_data, control_signals    registered operands and control word
//
// Build option: define ID_WB_BYPASS_EN so that a write-back to Rs/Rd is forwarded into the
// outputs on the same edge. Without it, the outputs show the old value, and the new value
// appears one edge later.
module instruction_decode #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8,
    parameter int CTRL_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rstAll,
    input  logic [15:0]                instruction,
    input  logic [DATA_W-1:0]          WB_data,
    input  logic [$clog2(REG_CNT)-1:0] WB_address,
    input  logic                       write_enable,
    output logic [DATA_W-1:0]          Rs_data,
    output logic [DATA_W-1:0]          Rd_data,
    output logic [CTRL_W-1:0]          control_signals
);

    localparam int ADDR_W = $clog2(REG_CNT);

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_HLT  = 5'd1,
        OP_SETC = 5'd2,
        OP_MOV  = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_AND  = 5'd6,
        OP_OR   = 5'd7,
        OP_SHL  = 5'd8,
        OP_LDM  = 5'd9,
        OP_LDD  = 5'd10,
        OP_STD  = 5'd11
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_NOT  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SETC = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src_imm;
        alu_op_t alu_op;
        logic    halt;
    } ctrl_t;

    logic [DATA_W-1:0] regs [REG_CNT];

    opcode_t           opcode;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rd_addr;
    ctrl_t             ctrl_dec;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rd_val;

    assign opcode  = opcode_t'(instruction[15:11]);
    assign rs_addr = instruction[10:8];
    assign rd_addr = instruction[7:5];

    // The shamt/imm field is consumed by a later stage.
    logic unused_imm;
    assign unused_imm = &{1'b0, instruction[4:0]};

    always_comb begin
        ctrl_dec = '0;
        case (opcode)
            OP_HLT:  ctrl_dec.halt = 1'b1;
            OP_SETC: ctrl_dec.alu_op = ALU_SETC;
            OP_MOV: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_PASS;
            end
            OP_ADD: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_SUB;
            end
            OP_AND: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_AND;
            end
            OP_OR: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_OR;
            end
            OP_SHL: begin
                ctrl_dec.reg_write   = 1'b1;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.alu_op      = ALU_SHL;
            end
            OP_LDM: begin
                ctrl_dec.reg_write   = 1'b1;
                ctrl_dec.alu_src_imm = 1'b1;
            end
            OP_LDD: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.mem_read  = 1'b1;
            end
            OP_STD:  ctrl_dec.mem_write = 1'b1;
            default: ctrl_dec = '0;  // NOP and every unlisted opcode
        endcase
    end

    // Operand read. With forwarding, a write-back landing on the register being read
    // wins over the stale array contents. rstAll overrides the outputs anyway, so
    // forwarding never leaks through a full reset.
`ifdef ID_WB_BYPASS_EN
    assign rs_val = (write_enable && (WB_address == rs_addr)) ? WB_data : regs[rs_addr];
    assign rd_val = (write_enable && (WB_address == rd_addr)) ? WB_data : regs[rd_addr];
`else
    assign rs_val = regs[rs_addr];
    assign rd_val = regs[rd_addr];
`endif

    // Register file: rstAll clears it and drops any write-back on the same edge.
    // A plain rst does not block the write.
    always_ff @(posedge clk) begin
        if (rstAll) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[WB_address] <= WB_data;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (rstAll || rst) begin
            Rs_data         <= '0;
            Rd_data         <= '0;
            control_signals <= '0;
        end else begin
            Rs_data         <= rs_val;
            Rd_data         <= rd_val;
            control_signals <= CTRL_W'(ctrl_dec);
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rstAll = 1'b0;
    logic [15:0] instruction = '0;
    logic [15:0] WB_data = '0;
    logic [2:0]  WB_address = '0;
    logic        write_enable = 1'b0;
    logic [15:0] Rs_data;
    logic [15:0] Rd_data;
    logic [7:0]  control_signals;

    instruction_decode dut (
        .clk             (clk),
        .rst             (rst),
        .rstAll          (rstAll),
        .instruction     (instruction),
        .WB_data         (WB_data),
        .WB_address      (WB_address),
        .write_enable    (write_enable),
        .Rs_data         (Rs_data),
        .Rd_data         (Rd_data),
        .control_signals (control_signals)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state.
    logic [15:0] m_regs [8];
    logic [7:0]  ctrl_tab [32];

    // Expected values of the most recent cycle.
    logic [15:0] e_rs;
    logic [15:0] e_rd;
    logic [7:0]  e_ctrl;

    typedef struct {
        logic [15:0] ins;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        r;
        logic        ra;
        logic [15:0] x_rs;
        logic [15:0] x_rd;
        logic [7:0]  x_ctrl;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(logic [15:0] ins, logic we, logic [2:0] wa, logic [15:0] wd,
                                logic r, logic ra, logic [15:0] xs, logic [15:0] xd, logic [7:0] xc);
        vec_t v;
        v.ins = ins; v.we = we; v.wa = wa; v.wd = wd; v.r = r; v.ra = ra;
        v.x_rs = xs; v.x_rd = xd; v.x_ctrl = xc;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    // Applies one cycle of inputs, advances the model, and samples just after the edge.
    task automatic cycle(input logic [15:0] ins, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic r, input logic ra);
        logic [2:0] rs_a;
        logic [2:0] rd_a;
        instruction  = ins;
        write_enable = we;
        WB_address   = wa;
        WB_data      = wd;
        rst          = r;
        rstAll       = ra;
        rs_a = ins[10:8];
        rd_a = ins[7:5];
        if (ra) begin
            e_rs = 0; e_rd = 0; e_ctrl = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
        end else begin
            if (r) begin
                e_rs = 0; e_rd = 0; e_ctrl = 0;
            end else begin
                e_rs   = (BYP && we && wa == rs_a) ? wd : m_regs[rs_a];
                e_rd   = (BYP && we && wa == rd_a) ? wd : m_regs[rd_a];
                e_ctrl = ctrl_tab[ins[15:11]];
            end
            if (we) m_regs[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rs"},   Rs_data, e_rs);
        check({tag, ".rd"},   Rd_data, e_rd);
        check({tag, ".ctrl"}, {8'h00, control_signals}, {8'h00, e_ctrl});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ctrl_tab[i] = 8'h00;
        ctrl_tab[1]  = 8'h01; ctrl_tab[2]  = 8'h0E; ctrl_tab[3]  = 8'h80;
        ctrl_tab[4]  = 8'h84; ctrl_tab[5]  = 8'h86; ctrl_tab[6]  = 8'h88;
        ctrl_tab[7]  = 8'h8A; ctrl_tab[8]  = 8'h9C; ctrl_tab[9]  = 8'h90;
        ctrl_tab[10] = 8'hC0; ctrl_tab[11] = 8'h20;
        for (int i = 0; i < 8; i++) m_regs[i] = 'x;

        // Directed table: ins, we, wa, wd, rst, rstAll, exp Rs, exp Rd, exp ctrl
        vecs[0]  = mk(16'h1940, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 8'h00);
        vecs[1]  = mk(16'h1940, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 8'h80);
        vecs[2]  = mk(16'h1940, 1, 2, 16'h112F, 0, 0, 16'h0000, BYP ? 16'h112F : 16'h0000, 8'h80);
        vecs[3]  = mk(16'h1940, 0, 2, 16'h1129, 0, 0, 16'h0000, 16'h112F, 8'h80);
        vecs[4]  = mk(16'h1940, 1, 2, 16'h1926, 0, 0, 16'h0000, BYP ? 16'h1926 : 16'h112F, 8'h80);
        vecs[5]  = mk(16'h1940, 0, 2, 16'h1926, 0, 0, 16'h0000, 16'h1926, 8'h80);
        vecs[6]  = mk(16'h1940, 1, 1, 16'hABCD, 0, 0, BYP ? 16'hABCD : 16'h0000, 16'h1926, 8'h80);
        vecs[7]  = mk(16'h2140, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 8'h00);
        vecs[8]  = mk(16'h2140, 0, 0, 16'h0000, 0, 0, 16'hABCD, 16'h1926, 8'h84);
        // rst still lets the write-back through; then Rs==Rd reads it on both outputs.
        vecs[9]  = mk(16'h1B60, 1, 3, 16'h5555, 1, 0, 16'h0000, 16'h0000, 8'h00);
        vecs[10] = mk(16'h1B60, 0, 0, 16'h0000, 0, 0, 16'h5555, 16'h5555, 8'h80);
        // rst together with rstAll acts as rstAll: the write is dropped and R1 is cleared.
        vecs[11] = mk(16'h2420, 1, 4, 16'h7777, 1, 1, 16'h0000, 16'h0000, 8'h00);
        vecs[12] = mk(16'h2420, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 8'h84);

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].ins, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r, vecs[i].ra);
            check($sformatf("vec%0d.rs", i), Rs_data, vecs[i].x_rs);
            check($sformatf("vec%0d.rd", i), Rd_data, vecs[i].x_rd);
            check($sformatf("vec%0d.ctrl", i), {8'h00, control_signals}, {8'h00, vecs[i].x_ctrl});
        end

        // Opcode sweep against the decode table.
        for (int op = 0; op < 32; op++) begin
            logic [4:0] op5;
            op5 = 5'(op);
            cycle({op5, 3'd1, 3'd2, 5'h1F}, 0, 0, 16'h0000, 0, 0);
            check_model($sformatf("op%0d", op));
        end
        cycle(16'h0800, 0, 0, 16'h0000, 0, 0);
        check("hlt_0800", {8'h00, control_signals}, 16'h0001);

        // Load R0..R7, confirm them, then rstAll with a write pending clears everything.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = 3'(i);
            cycle(16'h0000, 1, a, 16'h1000 + 16'(i) * 16'h0111, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            logic [2:0] b;
            a = 3'(i);
            b = 3'(7 - i);
            cycle({5'd3, a, b, 5'd0}, 0, 0, 16'h0000, 0, 0);
            check_model($sformatf("load%0d", i));
        end
        cycle(16'h0000, 1, 5, 16'hFFFF, 0, 1);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            logic [2:0] b;
            a = 3'(i);
            b = 3'(7 - i);
            cycle({5'd4, a, b, 5'd0}, 0, 0, 16'h0000, 0, 0);
            check($sformatf("clr%0d.rs", i), Rs_data, 16'h0000);
            check($sformatf("clr%0d.rd", i), Rd_data, 16'h0000);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic [15:0] ins;
            logic [15:0] wd;
            logic [2:0]  wa;
            logic        we;
            logic        r;
            logic        ra;
            ins = 16'($urandom);
            wd  = 16'($urandom);
            wa  = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 15) == 0);
            ra  = ($urandom_range(0, 40) == 0);
            cycle(ins, we, wa, wd, r, ra);
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
